// File: rtl/bcd_convert_scheduler_if.sv
// bcd_convert_scheduler_if: start/done handshake between the scheduler and the binary-to-BCD converter
interface bcd_convert_scheduler_if #(parameter int WIDTH = 16) ();
  logic conv_start;
  logic [WIDTH-1:0] conv_value;
  logic conv_done;
  logic [15:0] conv_bcd;
  modport master (output conv_start, conv_value, input conv_done, conv_bcd);
  modport slave (input conv_start, conv_value, output conv_done, conv_bcd);
endinterface

// File: rtl/bcd_convert_scheduler.sv
// bcd_convert_scheduler: round-robin sharing of one serial binary-to-BCD converter among display channels
module bcd_convert_scheduler #(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_CH*WIDTH-1:0] i_ch_value,
  input  logic [NUM_CH-1:0] i_ch_enable,
  bcd_convert_scheduler_if.master conv,
  output logic [NUM_CH*16-1:0] o_bcd_out,
  output logic [NUM_CH-1:0] o_bcd_valid,
  output logic [$clog2(NUM_CH)-1:0] o_cur_ch,
  output logic o_busy,
  output logic o_err_timeout
);
  localparam int CW = $clog2(NUM_CH);
  localparam int CNTW = $clog2(TIMEOUT + 1);
  localparam int VW = (WIDTH > 14) ? WIDTH : 14;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cur_ch, r_last, w_grant;
  logic [NUM_CH-1:0] r_pending, r_valid, w_dirty;
  logic [WIDTH-1:0] r_shadow [NUM_CH];
  logic [WIDTH-1:0] r_snap, r_conv_value, w_raw_g, w_sat;
  logic [VW-1:0] w_ext;
  logic [NUM_CH*16-1:0] r_bcd;
  logic [CNTW-1:0] r_cnt;
  logic [2*NUM_CH-1:0] w_rot;
  logic r_err, w_any, w_timeout;
  int w_off, w_idx;
  always_comb begin
    w_dirty = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_dirty[i] = i_ch_enable[i] & (r_pending[i] | (i_ch_value[i*WIDTH +: WIDTH] != r_shadow[i]));
  end
  // Doubled vector rotated so bit 0 is the channel just after last_grant; wraps for any NUM_CH
  assign w_rot = {w_dirty, w_dirty} >> (r_last + 1'b1);
  assign w_any = |w_dirty;
  always_comb begin
    w_off = 0;
    for (int j = NUM_CH - 1; j >= 0; j--)
      if (w_rot[j]) w_off = j;
    w_idx = int'(r_last) + 1 + w_off;
    w_grant = CW'((w_idx >= NUM_CH) ? w_idx - NUM_CH : w_idx);
  end
  assign w_raw_g = i_ch_value[w_grant*WIDTH +: WIDTH];
  assign w_ext = VW'(w_raw_g);
  assign w_sat = (w_ext > VW'(9999)) ? WIDTH'(9999) : w_raw_g;
  always_comb begin
    w_next = r_state;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: w_next = w_any ? ISSUE : IDLE;
      ISSUE: w_next = WAIT;
      WAIT: begin
        if (conv.conv_done) w_next = STORE;
        else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
          w_next = IDLE;
          w_timeout = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cur_ch <= '0;
      r_last <= CW'(NUM_CH - 1);
      r_pending <= '1;
      r_valid <= '0;
      r_snap <= '0;
      r_conv_value <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
      if (r_state == IDLE && w_any) begin
        r_cur_ch <= w_grant;
        r_snap <= w_raw_g;
        r_conv_value <= w_sat;
      end
      if (r_state == ISSUE) begin
        r_shadow[r_cur_ch] <= r_snap;
        r_pending[r_cur_ch] <= 1'b0;
      end
      // A timed-out channel stays dirty through pending, so it is retried on a later grant
      if (w_timeout) begin
        r_err <= 1'b1;
        r_pending[r_cur_ch] <= 1'b1;
      end
      if (r_state == WAIT && conv.conv_done) begin
        r_bcd[r_cur_ch*16 +: 16] <= conv.conv_bcd;
        r_valid[r_cur_ch] <= 1'b1;
        r_last <= r_cur_ch;
      end
    end
  end
  assign conv.conv_start = (r_state == ISSUE);
  assign conv.conv_value = r_conv_value;
  assign o_bcd_out = r_bcd;
  assign o_bcd_valid = r_valid;
  assign o_cur_ch = r_cur_ch;
  assign o_busy = (r_state != IDLE);
  assign o_err_timeout = r_err;
endmodule
